// File: rtl/mem_wait_state_responder.sv
// Memory-side responder for the picorv32 native bus.
// Holds a word-addressed RAM, stretches every transaction by a fixed number of
// wait states, applies byte-strobed writes, flags out-of-range accesses and
// keeps saturating fetch/load/store counters.
module mem_wait_state_responder #(
    parameter int unsigned MEM_WORDS   = 512,  // power of two
    parameter int unsigned WAIT_CYCLES = 2,    // 0..15
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             oob_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int unsigned ADDR_W   = $clog2(MEM_WORDS);
    localparam logic        HAS_WAIT = (WAIT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // Request captured when it is accepted; the core may change its inputs
    // while we stall, so the access always uses this copy.
    logic [31:2] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        lat_instr;

    logic [3:0]  wcnt;

    // Set for the single IDLE cycle that follows a response. The core is still
    // dropping its previous request then, so a valid seen there is stale.
    logic        resp_gap;

    logic        accept;
    logic        in_range;
    logic        is_write;
    logic [ADDR_W-1:0] word_idx;

    // Byte offset bits are irrelevant for a word-wide RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[1:0];

    logic [31:0] ram [MEM_WORDS];

    assign accept   = (state == S_IDLE) && mem_valid && !resp_gap;
    assign is_write = (lat_wstrb != 4'b0000);
    assign word_idx = lat_addr[ADDR_W+1:2];
    // Anything with a bit set above the RAM's byte range is out of range.
    assign in_range = (lat_addr[31:ADDR_W+2] == '0);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept, count wait states or abort, then respond.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = HAS_WAIT ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    state_nxt = S_IDLE;
                end else if (wcnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: ready pulse and read data only while responding.
    always_comb begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0000_0000;
        if (state == S_RESP) begin
            mem_ready = 1'b1;
            if (!is_write && in_range) begin
                mem_rdata = ram[word_idx];
            end
        end
    end

    // Request latch, wait-state counter and post-response gap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_instr <= 1'b0;
            wcnt      <= '0;
            resp_gap  <= 1'b0;
        end else begin
            resp_gap <= (state == S_RESP);
            if (accept) begin
                lat_addr  <= mem_addr[31:2];
                lat_wdata <= mem_wdata;
                lat_wstrb <= mem_wstrb;
                lat_instr <= mem_instr;
                wcnt      <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // Traffic counters and sticky out-of-range flag, updated on the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
            oob_err   <= 1'b0;
        end else if (state == S_RESP) begin
            if (!in_range) begin
                oob_err <= 1'b1;
            end
            if (is_write) begin
                if (store_cnt != '1) store_cnt <= store_cnt + CNT_W'(1);
            end else if (lat_instr) begin
                if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
            end else begin
                if (load_cnt != '1) load_cnt <= load_cnt + CNT_W'(1);
            end
        end
    end

    // Byte-strobed RAM write, committed at the end of the response cycle.
    // NOTE: the RAM array has no reset so it maps onto memory macros; the
    // reset only has to keep the FSM out of S_RESP to discard a pending write.
    always_ff @(posedge clk) begin
        if (state == S_RESP && is_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) begin
                    ram[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
